// File: rtl/button_pkg.sv
// Shared definitions for the button event consumer: FSM state encoding,
// default timing constants and event counter width.
package button_pkg;

    localparam int HOLD_CYCLES_DEF   = 25_000_000;
    localparam int REPEAT_CYCLES_DEF = 5_000_000;
    localparam int CNT_W_DEF         = 26;
    localparam int EVT_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    // A button is considered held in any state other than IDLE.
    function automatic logic state_is_held(state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/button_event_if.sv
// Clean-level link between a debouncer (master) and the button event
// consumer (slave). The debouncer drives the level; the consumer returns
// single-cycle UI events, the held level and the press counter.
interface button_event_if;
    import button_pkg::*;

    logic                 i_clean;
    logic                 o_press;
    logic                 o_release;
    logic                 o_click;
    logic                 o_long_press;
    logic                 o_repeat_pulse;
    logic                 o_held;
    logic [EVT_CNT_W-1:0] o_event_count;

    modport master (
        output i_clean,
        input  o_press, o_release, o_click, o_long_press,
               o_repeat_pulse, o_held, o_event_count
    );

    modport slave (
        input  i_clean,
        output o_press, o_release, o_click, o_long_press,
               o_repeat_pulse, o_held, o_event_count
    );

endinterface

// File: rtl/button_event_timer.sv
// event_timer: up-counter with synchronous clear, count enable and a
// terminal-count compare against a run-time terminal value. The count
// saturates at the terminal value so it can never run past or wrap.
module event_timer
    import button_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == i_term);
    assign o_tc = w_tc;

    // Count register: clear dominates, otherwise advance until terminal.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/button_event.sv
// button_event: turns one debounced button level into single-cycle UI events
// (press, release, click, long press, optional auto-repeat) plus a held level
// and a wrapping press counter. All outputs are registered.
// Build option: define BUTTON_AUTO_REPEAT_EN to enable repeat pulses while
// long-held; without it repeat_pulse is tied low and the timer idles at 0.
//
// state        | meaning
// ST_IDLE      | button released, waiting for a rising edge of clean
// ST_PRESSED   | button down, timing toward the long-press threshold
// ST_LONG_HELD | long press reported, optionally timing repeat pulses
module button_event
    import button_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic            live_clock,
    input  logic            rst,
    button_event_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_prev;
    logic                 w_rise;
    logic                 w_fall;

    logic                 w_tmr_clr;
    logic                 w_tmr_en;
    logic [CNT_W-1:0]     w_tmr_term;
    logic                 w_tmr_tc;

    logic                 w_press;
    logic                 w_release;
    logic                 w_click;
    logic                 w_long;
    logic                 w_repeat;
    logic                 w_cnt_inc;

    logic                 r_press;
    logic                 r_release;
    logic                 r_click;
    logic                 r_long;
    logic                 r_repeat;
    logic                 r_held;
    logic [EVT_CNT_W-1:0] r_event_count;

    assign w_rise = bus.i_clean & ~r_prev;
    assign w_fall = ~bus.i_clean & r_prev;

    // The same timer measures the hold threshold and the repeat period.
    assign w_tmr_term = (r_state == ST_LONG_HELD) ? REP_TERM : HOLD_TERM;

    event_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (live_clock),
        .i_rst_n (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_term  (w_tmr_term),
        .o_tc    (w_tmr_tc)
    );

    // State and edge-detect registers.
    always_ff @(posedge live_clock or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_prev  <= bus.i_clean;
        end
    end

    // Next-state and event decode; a falling edge always beats a terminal count.
    always_comb begin
        w_next    = r_state;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_click   = 1'b0;
        w_long    = 1'b0;
        w_repeat  = 1'b0;
        w_cnt_inc = 1'b0;
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_next    = ST_PRESSED;
                    w_press   = 1'b1;
                    w_cnt_inc = 1'b1;
                    w_tmr_clr = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_next    = ST_IDLE;
                    w_release = 1'b1;
                    w_click   = 1'b1;
                    w_tmr_clr = 1'b1;
                end else if (w_tmr_tc) begin
                    w_next    = ST_LONG_HELD;
                    w_long    = 1'b1;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_tmr_en  = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) begin
                    w_next    = ST_IDLE;
                    w_release = 1'b1;
                    w_tmr_clr = 1'b1;
                end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (w_tmr_tc) begin
                        w_repeat  = 1'b1;
                        w_tmr_clr = 1'b1;
                    end else begin
                        w_tmr_en  = 1'b1;
                    end
`else
                    w_tmr_clr = 1'b1;
`endif
                end
            end
            default: begin
                w_next    = ST_IDLE;
                w_tmr_clr = 1'b1;
            end
        endcase
    end

    // Registered event pulses, held level and wrapping press counter.
    always_ff @(posedge live_clock or negedge rst) begin
        if (!rst) begin
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_click       <= 1'b0;
            r_long        <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_event_count <= '0;
        end else begin
            r_press   <= w_press;
            r_release <= w_release;
            r_click   <= w_click;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= state_is_held(w_next);
            if (w_cnt_inc) begin
                r_event_count <= r_event_count + 1'b1;
            end
        end
    end

    assign bus.o_press        = r_press;
    assign bus.o_release      = r_release;
    assign bus.o_click        = r_click;
    assign bus.o_long_press   = r_long;
    assign bus.o_repeat_pulse = r_repeat;
    assign bus.o_held         = r_held;
    assign bus.o_event_count  = r_event_count;

endmodule
